any1_fetch_queue: RTL
=====================

# any1_fetch_queue

Instruction fetch queue and aligner sitting between the I-cache fetch stage and the instruction decoder. It accepts 128-bit fetch bundles of four 32-bit instruction slots, discards slots before the fetch address and after a predicted-taken branch, and buffers the remaining instructions in a circular queue. It presents one instruction per cycle to the decoder as an `sInstAlignOut` record with a valid/ready handshake. A flush input empties the queue on pipeline redirect.

## Interface
- `DEPTH`, 8: queue entries; power of two, ≥4.
- `rst_i`  in  1  synchronous active-high reset
- `clk_i`  in  1  clock; all state changes on rising edge
- `flush_i`  in  1  redirect; discard all queued and incoming instructions
- `fetch_valid_i`  in  1  fetch bundle present
- `fetch_ready_o`  out  1  bundle will be accepted this cycle
- `fetch_ip_i`  in  Address  address of first wanted instruction; bits [3:2] select start slot
- `fetch_bundle_i`  in  128  slot k = bits [32k+31:32k]
- `fetch_pt_i`  in  1  bundle holds a predicted-taken branch
- `fetch_pt_slot_i`  in  2  slot of that branch
- `fetch_stream_i`  in  Stream width  stream tag copied to every instruction from the bundle
- `a2d_valid_o`  out  1  `a2d_out_o` holds a valid instruction
- `a2d_ready_i`  in  1  decoder consumes head this cycle
- `a2d_out_o`  out  sInstAlignOut  fields driven: `ip`, `ir`, `predict_taken`, `Stream`
- `count_o`  out  clog2(DEPTH)+1  entries held

## Operation
- Start slot s = `fetch_ip_i[3:2]`. End slot e = `fetch_pt_slot_i` if `fetch_pt_i`, else 3. If e < s, the pt marking is ignored and e = 3.
- Slots s..e are written, in order, at `wr_ptr`, `wr_ptr+1`, … Number written n = e−s+1 (1..4).
- Entry contents: `ir` = slot word; `ip` = {`fetch_ip_i[AWID-1:4]`, slot[1:0], 2'b00}; `predict_taken` = 1 only for slot e when `fetch_pt_i` was set with e ≥ s; `Stream` = `fetch_stream_i`.
- `fetch_ready_o` = !`rst_i` & !`flush_i` & (DEPTH − `count` ≥ 4), computed from registered `count` only; a same-cycle pop does not create space.
- Push occurs when `fetch_valid_i` & `fetch_ready_o`. Pop occurs when `a2d_valid_o` & `a2d_ready_i`.
- Pointers are clog2(DEPTH) bits and wrap modulo DEPTH. `count` next = `count` + (push ? n : 0) − (pop ? 1 : 0). It never exceeds DEPTH and never underflows.
- `a2d_valid_o` = (`count` ≠ 0). `a2d_out_o` = entry at `rd_ptr`, read combinationally from registered storage.
- Flush: next cycle `count`=0, `rd_ptr`=`wr_ptr`=0. Any push or pop in the flush cycle is discarded.
- Reset: `count`=0, pointers=0, storage valid cleared. `a2d_valid_o`=0, `fetch_ready_o`=0 during reset. `a2d_out_o` fields read as zero while `count`=0.
- Reset or flush asserted mid-stream behave identically to the above regardless of handshake inputs.

## Timing
- Bundle accepted at edge N: the first instruction is visible at the head after N when the queue was empty. Latency is 1 cycle, with no bypass.
- One pop per cycle maximum. Throughput is 1 instruction/cycle sustained while fetch keeps ≥1 entry queued.
- Simultaneous push and pop in one cycle: both take effect. The popped entry is the old head.
- Full: `count` > DEPTH−4 deasserts `fetch_ready_o`. The bundle must be held by the source until accepted.
- A `fetch_ready_o` → `fetch_valid_i` combinational dependence is forbidden on the source side. `fetch_ready_o` does not depend on `fetch_valid_i` or `a2d_ready_i`.

## Test plan
- Reset, then bundle ip=0x1000, words A0..A3, no pt, decoder ready → head at next cycle: ip 0x1000/A0, then 0x1004/A1, 0x1008/A2, 0x100C/A3 on consecutive cycles; count 4→0.
- Bundle ip=0x2008, pt=1, pt_slot=2 → exactly one entry: ip 0x2008, pt=1. Repeat with pt_slot=0 (< s) → two entries 0x2008, 0x200C, both pt=0.
- Decoder stalled, push two full bundles with DEPTH=8 → count 8, `fetch_ready_o`=0. One pop → count 7, ready stays 0 until count ≤4. Order is preserved across pointer wrap.
- Queue holding 3 entries; same cycle push of 4 slots plus pop → count 6, head advances by one.
- Queue holding 5 entries, flush with `fetch_valid_i`=1 → next cycle count 0, `a2d_valid_o`=0. The next bundle 0x3000 appears as head one cycle after acceptance.
- Assert `rst_i` with a full queue and `a2d_ready_i`=1 → next cycle count 0, `a2d_valid_o`=0, and `fetch_ready_o` returns to 1 the cycle after reset drops.

Source files
------------

// File: rtl/any1_fetch_queue.sv
// any1_fetch_queue: fetch bundle aligner and circular instruction queue feeding the decoder
package any1_fetch_queue_pkg;
  localparam int AWID = 32;
  localparam int SWID = 4;
  typedef struct packed {
    logic [AWID-1:0] ip;
    logic [31:0] ir;
    logic predict_taken;
    logic [SWID-1:0] Stream;
  } sInstAlignOut;
endpackage

module any1_fetch_queue
  import any1_fetch_queue_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic rst_i,
  input  logic clk_i,
  input  logic flush_i,
  input  logic fetch_valid_i,
  output logic fetch_ready_o,
  input  logic [AWID-1:0] fetch_ip_i,
  input  logic [127:0] fetch_bundle_i,
  input  logic fetch_pt_i,
  input  logic [1:0] fetch_pt_slot_i,
  input  logic [SWID-1:0] fetch_stream_i,
  output logic a2d_valid_o,
  input  logic a2d_ready_i,
  output sInstAlignOut a2d_out_o,
  output logic [$clog2(DEPTH):0] count_o
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  sInstAlignOut mem [DEPTH];
  sInstAlignOut wdata [4];
  logic [PW-1:0] rd_ptr, wr_ptr;
  logic [CW-1:0] count;
  logic [1:0] s, e;
  logic [2:0] n;
  logic pt_ok, push, pop, unused_ip;
  assign unused_ip = ^fetch_ip_i[1:0];
  // slot window of the incoming bundle and the entries it produces
  always_comb begin
    s = fetch_ip_i[3:2];
    pt_ok = fetch_pt_i && fetch_pt_slot_i >= s;
    e = pt_ok ? fetch_pt_slot_i : 2'd3;
    n = {1'b0, e} - {1'b0, s} + 3'd1;
    for (int i = 0; i < 4; i++) begin
      wdata[i].ip = {fetch_ip_i[AWID-1:4], s + 2'(i), 2'b00};
      wdata[i].ir = fetch_bundle_i[32*(s + 2'(i)) +: 32];
      wdata[i].predict_taken = pt_ok && (s + 2'(i)) == e;
      wdata[i].Stream = fetch_stream_i;
    end
  end
  assign fetch_ready_o = !rst_i && !flush_i && count <= CW'(DEPTH - 4);
  assign push = fetch_valid_i && fetch_ready_o;
  assign a2d_valid_o = count != '0;
  assign pop = a2d_valid_o && a2d_ready_i;
  assign a2d_out_o = a2d_valid_o ? mem[rd_ptr] : '0;
  assign count_o = count;
  // pointer and occupancy bookkeeping; flush discards the cycle's push and pop
  always_ff @(posedge clk_i) begin
    if (rst_i || flush_i) begin
      count <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
    end else begin
      count <= count + (push ? CW'(n) : '0) - (pop ? CW'(1) : '0);
      wr_ptr <= push ? wr_ptr + PW'(n) : wr_ptr;
      rd_ptr <= pop ? rd_ptr + PW'(1) : rd_ptr;
    end
  end
  // storage write of the accepted slots; push is already blocked during reset and flush
  always_ff @(posedge clk_i) begin
    for (int i = 0; i < 4; i++)
      if (push && 3'(i) < n) mem[wr_ptr + PW'(i)] <= wdata[i];
  end
endmodule
